windowed_register_file: RTL and testbench

Parametrised SPARC V8 windowed integer register file: the next-generation replacement for the fixed four-window register file in the datapath. It owns the physical register array, the current window pointer (CWP) and the window invalid mask (WIM), and executes SAVE/RESTORE/trap-entry/RETT window moves. It raises registered window_overflow and window_underflow pulses that the control unit turns into traps. Sits between the ALU output bus (write data) and the ALUA/ALUB operand muxes (read data).

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_window_map.sv | 29 ++
 rtl/windowed_register_file.sv | 114 +++++++++++
 tb/tb_windowed_register_file.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the windowed register file and its address mapper.
package rf_pkg;

  localparam int unsigned NWINDOWS_DEFAULT = 8;

  function automatic int unsigned cwp_width(input int unsigned nwin);
    return (nwin <= 2) ? 1 : $clog2(nwin);
  endfunction

  function automatic int unsigned phys_count(input int unsigned nwin);
    return 8 + 16 * nwin;
  endfunction

  // Window-move winner for a cycle, listed in decreasing priority
  typedef enum logic [2:0] {
    MOVE_NONE,
    MOVE_LOAD,
    MOVE_TRAP,
    MOVE_SAVE,
    MOVE_RESTORE,
    MOVE_RETT
  } move_t;

endpackage

// File: rtl/rf_window_map.sv
// Combinational logical-to-physical register index mapper for one port.
module rf_window_map
  import rf_pkg::*;
#(
  parameter  int unsigned NWINDOWS = NWINDOWS_DEFAULT,
  localparam int unsigned CWP_W    = cwp_width(NWINDOWS),
  localparam int unsigned PHYS_W   = $clog2(phys_count(NWINDOWS))
) (
  input  logic [4:0]        addr,
  input  logic [CWP_W-1:0]  cwp,
  output logic [PHYS_W-1:0] phys
);

  int unsigned off;

  always_comb begin
    off  = 0;
    phys = '0;
    if (addr < 5'd8) begin
      phys = PHYS_W'(addr);
    end else begin
      // Offset never exceeds 2x the windowed span, so one conditional subtract is an exact modulo
      off = 16 * 32'(cwp) + 32'(addr) - 32'd8;
      if (off >= 16 * NWINDOWS) off = off - 16 * NWINDOWS;
      phys = PHYS_W'(32'd8 + off);
    end
  end

endmodule

// File: rtl/windowed_register_file.sv
// SPARC V8 windowed integer register file with CWP/WIM and window-move trap flags.
// Optional build macro: RF_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module windowed_register_file
  import rf_pkg::*;
#(
  parameter  int unsigned NWINDOWS = NWINDOWS_DEFAULT,
  parameter  int unsigned DATA_W   = 32,
  localparam int unsigned CWP_W    = cwp_width(NWINDOWS)
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [4:0]          PA_addr,
  input  logic [4:0]          PB_addr,
  output logic [DATA_W-1:0]   PA_out,
  output logic [DATA_W-1:0]   PB_out,
  input  logic [4:0]          PC_addr,
  input  logic [DATA_W-1:0]   PC_in,
  input  logic                write_enable,
  input  logic                save,
  input  logic                restore,
  input  logic                rett,
  input  logic                trap_entry,
  input  logic                cwp_load,
  input  logic [CWP_W-1:0]    cwp_in,
  input  logic                wim_load,
  input  logic [NWINDOWS-1:0] wim_in,
  output logic [CWP_W-1:0]    cwp_out,
  output logic [NWINDOWS-1:0] wim_out,
  output logic                window_overflow,
  output logic                window_underflow,
  output logic                cwp_range_err
);

  localparam int unsigned PHYS_N = phys_count(NWINDOWS);
  localparam int unsigned PHYS_W = $clog2(PHYS_N);

  logic [DATA_W-1:0]   mem [PHYS_N];
  logic [CWP_W-1:0]    cwp_q, cwp_dec, cwp_inc, cwp_nxt;
  logic [NWINDOWS-1:0] wim_q;
  logic [PHYS_W-1:0]   pa_phys, pb_phys, pc_phys;
  logic                ovf_nxt, unf_nxt, rerr_nxt;
  logic                wr_en;
  move_t               move;

  rf_window_map #(.NWINDOWS(NWINDOWS)) u_map_a (.addr(PA_addr), .cwp(cwp_q), .phys(pa_phys));
  rf_window_map #(.NWINDOWS(NWINDOWS)) u_map_b (.addr(PB_addr), .cwp(cwp_q), .phys(pb_phys));
  rf_window_map #(.NWINDOWS(NWINDOWS)) u_map_c (.addr(PC_addr), .cwp(cwp_q), .phys(pc_phys));

  assign wr_en   = write_enable && (PC_addr != 5'd0);
  assign cwp_dec = (cwp_q == '0) ? CWP_W'(NWINDOWS - 1) : cwp_q - CWP_W'(1);
  assign cwp_inc = (32'(cwp_q) == NWINDOWS - 1) ? '0 : cwp_q + CWP_W'(1);

  always_comb begin
    move = MOVE_NONE;
    if (cwp_load)        move = MOVE_LOAD;
    else if (trap_entry) move = MOVE_TRAP;
    else if (save)       move = MOVE_SAVE;
    else if (restore)    move = MOVE_RESTORE;
    else if (rett)       move = MOVE_RETT;
  end

  always_comb begin
    cwp_nxt  = cwp_q;
    ovf_nxt  = 1'b0;
    unf_nxt  = 1'b0;
    rerr_nxt = 1'b0;
    case (move)
      MOVE_LOAD: begin
        if (32'(cwp_in) < NWINDOWS) cwp_nxt = cwp_in;
        else                        rerr_nxt = 1'b1;
      end
      MOVE_TRAP: cwp_nxt = cwp_dec;
      MOVE_SAVE: begin
        if (wim_q[cwp_dec]) ovf_nxt = 1'b1;
        else                cwp_nxt = cwp_dec;
      end
      MOVE_RESTORE, MOVE_RETT: begin
        if (wim_q[cwp_inc]) unf_nxt = 1'b1;
        else                cwp_nxt = cwp_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int unsigned i = 0; i < PHYS_N; i++) mem[i] <= '0;
      cwp_q            <= '0;
      wim_q            <= '0;
      window_overflow  <= 1'b0;
      window_underflow <= 1'b0;
      cwp_range_err    <= 1'b0;
    end else begin
      if (wr_en) mem[pc_phys] <= PC_in;
      if (wim_load) wim_q <= wim_in;
      cwp_q            <= cwp_nxt;
      window_overflow  <= ovf_nxt;
      window_underflow <= unf_nxt;
      cwp_range_err    <= rerr_nxt;
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  assign PA_out = (PA_addr == 5'd0) ? '0 : (wr_en && pa_phys == pc_phys) ? PC_in : mem[pa_phys];
  assign PB_out = (PB_addr == 5'd0) ? '0 : (wr_en && pb_phys == pc_phys) ? PC_in : mem[pb_phys];
`else
  assign PA_out = (PA_addr == 5'd0) ? '0 : mem[pa_phys];
  assign PB_out = (PB_addr == 5'd0) ? '0 : mem[pb_phys];
`endif

  assign cwp_out = cwp_q;
  assign wim_out = wim_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Scoreboard bench for windowed_register_file (NWINDOWS=8 main instance, NWINDOWS=5 wrap/range instance).
module tb_windowed_register_file;

  localparam int K_PA = 0, K_PB = 1, K_CWP = 2, K_WIM = 3, K_OVF = 4, K_UNF = 5,
                 K_RERR = 6, K_CWP5 = 7, K_RERR5 = 8;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        Clk = 1'b0, Clr = 1'b1;
  logic [4:0]  PA_addr = '0, PB_addr = '0, PC_addr = '0;
  logic [31:0] PC_in = '0;
  logic        write_enable = 1'b0, save = 1'b0, restore = 1'b0, rett = 1'b0, trap_entry = 1'b0;
  logic        cwp_load = 1'b0, wim_load = 1'b0;
  logic [2:0]  cwp_in = '0;
  logic [7:0]  wim_in = '0;
  logic [31:0] PA_out, PB_out;
  logic [2:0]  cwp_out;
  logic [7:0]  wim_out;
  logic        window_overflow, window_underflow, cwp_range_err;

  logic        save5 = 1'b0, restore5 = 1'b0, cwp_load5 = 1'b0;
  logic [2:0]  cwp_in5 = '0;
  logic        zero = 1'b0;
  logic [4:0]  wim_zero5 = '0;
  logic [31:0] pa5, pb5;
  logic [2:0]  cwp5;
  logic [4:0]  wim5;
  logic        ovf5, unf5, rerr5;

  windowed_register_file #(.NWINDOWS(8), .DATA_W(32)) u_dut (
    .Clk(Clk), .Clr(Clr), .PA_addr(PA_addr), .PB_addr(PB_addr), .PA_out(PA_out), .PB_out(PB_out),
    .PC_addr(PC_addr), .PC_in(PC_in), .write_enable(write_enable), .save(save), .restore(restore),
    .rett(rett), .trap_entry(trap_entry), .cwp_load(cwp_load), .cwp_in(cwp_in), .wim_load(wim_load),
    .wim_in(wim_in), .cwp_out(cwp_out), .wim_out(wim_out), .window_overflow(window_overflow),
    .window_underflow(window_underflow), .cwp_range_err(cwp_range_err)
  );

  windowed_register_file #(.NWINDOWS(5), .DATA_W(32)) u_dut5 (
    .Clk(Clk), .Clr(Clr), .PA_addr(PA_addr), .PB_addr(PB_addr), .PA_out(pa5), .PB_out(pb5),
    .PC_addr(PC_addr), .PC_in(PC_in), .write_enable(zero), .save(save5), .restore(restore5),
    .rett(zero), .trap_entry(zero), .cwp_load(cwp_load5), .cwp_in(cwp_in5), .wim_load(zero),
    .wim_in(wim_zero5), .cwp_out(cwp5), .wim_out(wim5), .window_overflow(ovf5),
    .window_underflow(unf5), .cwp_range_err(rerr5)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the live outputs mid-cycle
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_PA:    act = PA_out;
          K_PB:    act = PB_out;
          K_CWP:   act = 32'(cwp_out);
          K_WIM:   act = 32'(wim_out);
          K_OVF:   act = 32'(window_overflow);
          K_UNF:   act = 32'(window_underflow);
          K_RERR:  act = 32'(cwp_range_err);
          K_CWP5:  act = 32'(cwp5);
          K_RERR5: act = 32'(rerr5);
          default: act = 'x;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    Clr = 1'b0;
    // Write r5 then reset: register contents and window state must clear
    write_enable = 1'b1; PC_addr = 5'd5; PC_in = 32'hDEADBEEF;
    step(); write_enable = 1'b0; PA_addr = 5'd5;
    expect_val(K_PA, 32'hDEADBEEF, "r5_written");
    step(); Clr = 1'b1;
    expect_val(K_PA, 32'h0, "r5_after_reset");
    expect_val(K_CWP, 32'h0, "cwp_reset");
    expect_val(K_WIM, 32'h0, "wim_reset");
    expect_val(K_OVF, 32'h0, "ovf_reset");
    step(); Clr = 1'b0;
    write_enable = 1'b1; PC_addr = 5'd0; PC_in = 32'h1234;
    step(); write_enable = 1'b0; PA_addr = 5'd0;
    expect_val(K_PA, 32'h0, "r0_zero");

    // Global r3 at CWP 0, then r8 at CWP 3 aliases r24 at CWP 2
    write_enable = 1'b1; PC_addr = 5'd3; PC_in = 32'h333;
    step(); write_enable = 1'b0; cwp_load = 1'b1; cwp_in = 3'd3;
    step(); cwp_load = 1'b0;
    expect_val(K_CWP, 32'd3, "cwp_load3");
    expect_val(K_RERR, 32'd0, "rerr_inrange");
    write_enable = 1'b1; PC_addr = 5'd8; PC_in = 32'hA5A5A5A5;
    step(); write_enable = 1'b0; save = 1'b1;
    step(); save = 1'b0; PA_addr = 5'd24;
    expect_val(K_CWP, 32'd2, "save_cwp2");
    expect_val(K_PA, 32'hA5A5A5A5, "r24_alias");
    cwp_load = 1'b1; cwp_in = 3'd5;
    step(); cwp_load = 1'b0; PB_addr = 5'd3;
    expect_val(K_CWP, 32'd5, "cwp_load5");
    expect_val(K_PB, 32'h333, "global_r3");

    // Wrap-around with WIM clear
    cwp_load = 1'b1; cwp_in = 3'd0;
    step(); cwp_load = 1'b0; save = 1'b1;
    step(); save = 1'b0; restore = 1'b1;
    expect_val(K_CWP, 32'd7, "save_wrap");
    step(); restore = 1'b0; rett = 1'b1;
    expect_val(K_CWP, 32'd0, "restore_wrap");
    step(); rett = 1'b0;
    expect_val(K_CWP, 32'd1, "rett_inc");

    // WIM-guarded moves
    wim_load = 1'b1; wim_in = 8'h04; cwp_load = 1'b1; cwp_in = 3'd3;
    step(); wim_load = 1'b0; cwp_load = 1'b0; save = 1'b1;
    expect_val(K_WIM, 32'h04, "wim_loaded");
    step(); save = 1'b0;
    expect_val(K_OVF, 32'd1, "overflow_pulse");
    expect_val(K_CWP, 32'd3, "overflow_cwp_held");
    step(); trap_entry = 1'b1;
    expect_val(K_OVF, 32'd0, "overflow_one_cycle");
    step(); trap_entry = 1'b0; cwp_load = 1'b1; cwp_in = 3'd1;
    expect_val(K_CWP, 32'd2, "trap_entry_cwp");
    expect_val(K_OVF, 32'd0, "trap_no_flag");
    step(); cwp_load = 1'b0; restore = 1'b1;
    step(); restore = 1'b0;
    expect_val(K_UNF, 32'd1, "underflow_pulse");
    expect_val(K_CWP, 32'd1, "underflow_cwp_held");
    step(); cwp_load = 1'b1; cwp_in = 3'd3;
    expect_val(K_UNF, 32'd0, "underflow_one_cycle");
    // Load beats a save that would otherwise overflow
    step(); cwp_load = 1'b1; cwp_in = 3'd6; save = 1'b1;
    step(); cwp_load = 1'b0; save = 1'b0;
    expect_val(K_CWP, 32'd6, "load_beats_save");
    expect_val(K_OVF, 32'd0, "dropped_save_no_flag");

    // Same-cycle write/read on r17
    write_enable = 1'b1; PC_addr = 5'd17; PC_in = 32'h11;
    step(); PC_in = 32'h55; PA_addr = 5'd17;
`ifdef RF_WRITE_BYPASS_EN
    expect_val(K_PA, 32'h55, "r17_bypass");
`else
    expect_val(K_PA, 32'h11, "r17_no_bypass");
`endif
    step(); write_enable = 1'b0;
    expect_val(K_PA, 32'h55, "r17_after_write");

    // Write concurrent with a window move lands in the old window
    write_enable = 1'b1; PC_addr = 5'd8; PC_in = 32'hCAFE; trap_entry = 1'b1;
    step(); write_enable = 1'b0; trap_entry = 1'b0; PA_addr = 5'd24;
    expect_val(K_CWP, 32'd5, "trap_with_write_cwp");
    expect_val(K_PA, 32'hCAFE, "write_old_cwp");

    // Five-window instance: modulo wrap and out-of-range load
    save5 = 1'b1;
    step(); save5 = 1'b0; restore5 = 1'b1;
    expect_val(K_CWP5, 32'd4, "n5_save_wrap");
    step(); restore5 = 1'b0; cwp_load5 = 1'b1; cwp_in5 = 3'd7;
    expect_val(K_CWP5, 32'd0, "n5_restore_wrap");
    step(); cwp_load5 = 1'b0;
    expect_val(K_RERR5, 32'd1, "n5_range_err");
    expect_val(K_CWP5, 32'd0, "n5_range_cwp_held");
    step();
    expect_val(K_RERR5, 32'd0, "n5_range_err_one_cycle");

    @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
